// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: reads one or two program bytes at the PC,
// advances the PC once per byte, and holds each assembled instruction
// until the execute stage accepts it.
module instruction_fetch #(
  parameter int          ADDR_W       = 12,
  parameter logic [15:0] TWO_BYTE_MAP = 16'h00FF
) (
  input  logic              clk,
  input  logic              notReset,
  input  logic [ADDR_W-1:0] pcAddress,
  output logic              incPC,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memRead,
  input  logic [7:0]        memData,
  input  logic              memReady,
  input  logic              flush,
  input  logic              instrAccept,
  output logic              instrValid,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic [ADDR_W-1:0] target,
  output logic              instrLong
);

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   first_is_long;

  // Opcode of the byte currently on the bus selects one- or two-byte format
  assign first_is_long = TWO_BYTE_MAP[memData[7:4]];

  // State register
  always_ff @(posedge clk) begin
    if (!notReset) begin
      state <= FETCH_HI;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush restarts fetch and drops any partial instruction
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = FETCH_HI;
    end else begin
      case (state)
        FETCH_HI: if (memReady) next_state = first_is_long ? FETCH_LO : HOLD;
        FETCH_LO: if (memReady) next_state = HOLD;
        HOLD:     if (instrAccept) next_state = FETCH_HI;
        default:  next_state = FETCH_HI;
      endcase
    end
  end

  // Memory handshake outputs; a flushed request is withdrawn so the byte is abandoned
  always_comb begin
    memAddress = pcAddress;
    memRead    = notReset & ~flush & (state != HOLD);
    incPC      = memRead & memReady;
  end

  // Instruction register: capture bytes on transfer, clear valid on accept or flush
  always_ff @(posedge clk) begin
    if (!notReset) begin
      instrValid <= 1'b0;
      opcode     <= 4'd0;
      operand    <= 4'd0;
      target     <= '0;
      instrLong  <= 1'b0;
    end else if (flush) begin
      instrValid <= 1'b0;
    end else begin
      case (state)
        FETCH_HI: begin
          if (memReady) begin
            opcode  <= memData[7:4];
            operand <= memData[3:0];
            if (!first_is_long) begin
              target     <= '0;
              instrLong  <= 1'b0;
              instrValid <= 1'b1;
            end
          end
        end
        FETCH_LO: begin
          if (memReady) begin
            target     <= ADDR_W'({operand, memData});
            instrLong  <= 1'b1;
            instrValid <= 1'b1;
          end
        end
        HOLD: begin
          if (instrAccept) instrValid <= 1'b0;
        end
        default: instrValid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a transaction-level model parses
// program memory into instructions and queues them; a monitor pops one each
// time the DUT presents a new instruction.
module tb_instruction_fetch;
  localparam int          ADDR_W = 12;
  localparam logic [15:0] MAP    = 16'h00FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              notReset;
  logic [ADDR_W-1:0] pcAddress;
  logic              incPC;
  logic [ADDR_W-1:0] memAddress;
  logic              memRead;
  logic [7:0]        memData;
  logic              memReady;
  logic              flush;
  logic              instrAccept;
  logic              instrValid;
  logic [3:0]        opcode;
  logic [3:0]        operand;
  logic [ADDR_W-1:0] target;
  logic              instrLong;

  instruction_fetch #(.ADDR_W(ADDR_W), .TWO_BYTE_MAP(MAP)) dut (
    .clk(clk), .notReset(notReset), .pcAddress(pcAddress), .incPC(incPC),
    .memAddress(memAddress), .memRead(memRead), .memData(memData),
    .memReady(memReady), .flush(flush), .instrAccept(instrAccept),
    .instrValid(instrValid), .opcode(opcode), .operand(operand),
    .target(target), .instrLong(instrLong)
  );

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        opd;
    logic [ADDR_W-1:0] tgt;
    logic              lng;
  } instr_t;

  instr_t     exp_q[$];
  logic [7:0] mem [4096];
  int         errors = 0;
  int         checks = 0;

  // PC register of the surrounding system, advanced by the DUT's incPC
  logic              load_pc = 1'b1;
  logic [ADDR_W-1:0] load_val = '0;
  always @(posedge clk) begin
    if (load_pc) pcAddress <= load_val;
    else if (incPC) pcAddress <= pcAddress + 1'b1;
  end

  // Reference model state: PC, bytes gathered for the current instruction, holding flag
  logic [ADDR_W-1:0] m_pc = '0;
  logic [7:0]        m_bytes[$];
  bit                m_hold = 0;
  bit                m_known = 0;
  bit                prev_rst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, and advance the model
  task automatic cycle(input bit rst_n, input bit rdy, input bit fl, input bit acc);
    logic [7:0] b;
    bit exp_rd;
    @(negedge clk);
    if (m_known) check("instrValid", {31'd0, instrValid}, {31'd0, m_hold});
    if (prev_rst) begin
      check("rst_opcode", {28'd0, opcode}, 32'd0);
      check("rst_operand", {28'd0, operand}, 32'd0);
      check("rst_target", {20'd0, target}, 32'd0);
      check("rst_instrLong", {31'd0, instrLong}, 32'd0);
    end
    notReset    = rst_n;
    memReady    = rdy;
    flush       = fl;
    instrAccept = acc;
    memData     = rdy ? mem[pcAddress] : 8'($urandom);
    #1;
    exp_rd = rst_n && !m_hold && !fl;
    if (m_known || !rst_n) begin
      check("memRead", {31'd0, memRead}, {31'd0, exp_rd});
      check("incPC", {31'd0, incPC}, {31'd0, exp_rd && rdy});
    end
    if (rst_n && m_known) check("memAddress", {20'd0, memAddress}, {20'd0, m_pc});
    if (!rst_n || fl) begin
      m_hold = 0;
      m_bytes.delete();
    end else if (m_hold) begin
      if (acc) m_hold = 0;
    end else if (rdy) begin
      b = mem[m_pc];
      m_pc = m_pc + 1'b1;
      m_bytes.push_back(b);
      if (m_bytes.size() == 1 && !MAP[b[7:4]]) begin
        exp_q.push_back('{op: b[7:4], opd: b[3:0], tgt: '0, lng: 1'b0});
        m_bytes.delete();
        m_hold = 1;
      end else if (m_bytes.size() == 2) begin
        exp_q.push_back('{op: m_bytes[0][7:4], opd: m_bytes[0][3:0],
                          tgt: ADDR_W'({m_bytes[0][3:0], m_bytes[1]}), lng: 1'b1});
        m_bytes.delete();
        m_hold = 1;
      end
    end
    if (!rst_n) m_known = 1;
    prev_rst = !rst_n;
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] pc0);
    load_pc  = 1'b1;
    load_val = pc0;
    m_pc     = pc0;
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    load_pc = 1'b0;
  endtask

  // Monitor: pop on each newly presented instruction, otherwise require stable outputs
  initial begin
    instr_t e;
    instr_t last;
    bit     pv;
    pv   = 0;
    last = '0;
    forever begin
      @(posedge clk);
      #2;
      if (instrValid === 1'b1 && !pv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", {31'd0, instrValid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("opcode", {28'd0, opcode}, {28'd0, e.op});
          check("operand", {28'd0, operand}, {28'd0, e.opd});
          check("target", {20'd0, target}, {20'd0, e.tgt});
          check("instrLong", {31'd0, instrLong}, {31'd0, e.lng});
          last = e;
        end
      end else if (instrValid === 1'b1 && pv) begin
        check("hold_stable", {opcode, operand, target, instrLong},
              {last.op, last.opd, last.tgt, last.lng});
      end
      pv = (instrValid === 1'b1);
    end
  end

  initial begin
    notReset = 1'b0; memReady = 1'b0; flush = 1'b0; instrAccept = 1'b0; memData = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h7E; mem[3] = 8'h91;
    mem[4] = 8'h2F; mem[5] = 8'hB0; mem[6] = 8'h12; mem[12'hFFF] = 8'hC4;

    do_reset(12'h000);
    cycle(1, 1, 0, 0);                          // A5: one-byte
    cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);       // 3C 7E: two-byte, target C7E
    cycle(1, 1, 0, 1);
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);  // wait states
    cycle(1, 1, 0, 0);                          // 91
    for (int i = 0; i < 5; i++) cycle(1, i[0], 0, 0);         // hold, no accept
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 0);                          // 2F starts two-byte
    cycle(1, 1, 1, 0);                          // flush in FETCH_LO
    cycle(1, 1, 0, 0);                          // B0 one-byte
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 0);                          // 12 starts two-byte
    cycle(0, 1, 0, 0);                          // reset mid-FETCH_LO
    do_reset(12'hFFF);
    cycle(1, 1, 0, 0);                          // C4 at FFF, PC wraps
    cycle(1, 1, 0, 1);
    cycle(1, 1, 1, 1);                          // flush with nothing held

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) != 0, ($urandom % 4) != 0,
            $urandom_range(0, 19) == 0, ($urandom % 3) == 0);
    end
    cycle(1, 0, 0, 0);
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
